// File: rtl/rdm.sv
// rdm: sequential shift-and-add reconstruction, dividendo = quociente * divisor + resto.
// One operation takes N+1 cycles from the accepted start edge to the done pulse.
module rdm #(
    parameter int N = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N-1:0]             quociente,
    input  logic [N-1:0]             divisor,
    input  logic [N-1:0]             resto,
    output logic [2*N-1:0]           dividendo,
    output logic [$clog2(N+1)-1:0]   count,
    output logic                     busy,
    output logic                     done
);

    localparam int CW = $clog2(N+1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SOMA = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            accept_s;
    logic [N:0]      a_r;
    logic [N-1:0]    q_r;
    logic [N-1:0]    m_r;
    logic [N-1:0]    r_r;
    logic [CW-1:0]   count_r;
    logic [2*N-1:0]  dividendo_r;
    logic            busy_r;
    logic            done_r;
    logic [N:0]      sum_s;
    logic [2*N-1:0]  product_s;
    logic [2*N-1:0]  result_s;

    // Next-state decode; the last CALC edge is the one that takes count from 1 to 0.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s  = CALC;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            CALC: begin
                if (count_r == CW'(1)) begin
                    state_s = SOMA;
                end else begin
                    state_s = CALC;
                end
            end
            SOMA:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Conditional add of the multiplicand, plus the final product-with-addend sum.
    always_comb begin
        if (q_r[0]) begin
            sum_s = a_r + {1'b0, m_r};
        end else begin
            sum_s = a_r;
        end
        product_s = {a_r[N-1:0], q_r};
        result_s  = product_s + {{N{1'b0}}, r_r};
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: operand capture, shift-add iterations and result load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r         <= '0;
            q_r         <= '0;
            m_r         <= '0;
            r_r         <= '0;
            count_r     <= '0;
            dividendo_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= '0;
                        q_r     <= quociente;
                        m_r     <= divisor;
                        r_r     <= resto;
                        count_r <= CW'(N);
                    end
                end
                CALC: begin
                    // Shift {sum, Q} right: the add's low bit enters the multiplier register.
                    a_r     <= {1'b0, sum_s[N:1]};
                    q_r     <= {sum_s[0], q_r[N-1:1]};
                    count_r <= count_r - CW'(1);
                end
                SOMA:    dividendo_r <= result_s;
                default: count_r <= '0;
            endcase
        end
    end

    // Registered status flags derived from the upcoming state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s == CALC) || (state_s == SOMA);
            done_r <= (state_r == SOMA);
        end
    end

    assign dividendo = dividendo_r;
    assign count     = count_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_rdm.sv
// Self-checking bench for rdm: directed scenarios, closed-loop division sweep and
// randomized operations checked against q*d+r computed arithmetically.
module tb_rdm;

    localparam int N  = 5;
    localparam int CW = $clog2(N+1);

    logic            clk;
    logic            rst;
    logic            start;
    logic [N-1:0]    quociente;
    logic [N-1:0]    divisor;
    logic [N-1:0]    resto;
    logic [2*N-1:0]  dividendo;
    logic [CW-1:0]   count;
    logic            busy;
    logic            done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hold_val   = 0;
    int last_done  = 0;
    bit prev_ok    = 1'b0;

    rdm #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .quociente (quociente),
        .divisor   (divisor),
        .resto     (resto),
        .dividendo (dividendo),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
            check("idle_count", count, 0);
            check("idle_hold", dividendo, hold_val);
        end
        if (n > 0) prev_ok = 1'b0;
    endtask

    // One operation starting at the next edge; optionally disturbs inputs and re-pulses start mid-run.
    task automatic run_op(input int q, input int d, input int r, input int e, input bit disturb);
        int rv;
        quociente = q[N-1:0];
        divisor   = d[N-1:0];
        resto     = r[N-1:0];
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("e0_busy", busy, 1);
        check("e0_done", done, 0);
        check("e0_count", count, N);
        check("e0_hold", dividendo, hold_val);
        for (int k = 1; k <= N; k++) begin
            if (disturb) begin
                rv = $urandom;
                quociente = rv[N-1:0];
                divisor   = rv[2*N-1:N];
                resto     = rv[3*N-1:2*N];
                start     = (k == 3);
            end
            tick();
            check("calc_busy", busy, 1);
            check("calc_done", done, 0);
            check("calc_count", count, N - k);
            check("calc_hold", dividendo, hold_val);
        end
        start = 1'b0;
        tick();
        check("soma_done", done, 1);
        check("soma_busy", busy, 0);
        check("soma_count", count, 0);
        check("result", dividendo, e);
        hold_val = e;
        if (prev_ok) check("interval", cyc - last_done, N + 2);
        last_done = cyc;
        prev_ok   = 1'b1;
    endtask

    initial begin
        int q, d, r;
        rst = 1'b1;
        start = 1'b0;
        quociente = '0;
        divisor = '0;
        resto = '0;
        #2 rst = 1'b0;
        #2;
        check("rst_dividendo", dividendo, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        tick();
        rst = 1'b1;
        idle(2);

        run_op(2, 5, 1, 11, 1'b0);
        tick();
        check("post_done_low", done, 0);
        prev_ok = 1'b0;
        run_op(31, 31, 31, 992, 1'b0);
        run_op(0, 0, 0, 0, 1'b0);
        run_op(7, 0, 3, 3, 1'b0);
        idle(2);

        // Start re-pulsed and inputs scrambled mid-run must not affect the result.
        run_op(4, 3, 2, 14, 1'b1);
        idle(N + 3);

        // Asynchronous reset in the middle of a run.
        quociente = 5'd9;
        divisor   = 5'd7;
        resto     = 5'd5;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        check("mid_rst_dividendo", dividendo, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        hold_val = 0;
        tick();
        check("mid_rst_hold_done", done, 0);
        rst = 1'b1;
        idle(N + 3);
        run_op(13, 3, 0, 39, 1'b0);

        // Back-to-back pairs: consecutive calls issue start during the done cycle.
        run_op(6, 5, 4, 34, 1'b0);
        run_op(19, 17, 30, 353, 1'b0);
        idle(1);

        for (int i = 0; i < 32; i++) begin
            for (int j = 1; j < 32; j++) begin
                run_op(i / j, j, i % j, i, 1'b0);
            end
        end
        idle(1);

        for (int t = 0; t < 40; t++) begin
            q = $urandom_range(0, 31);
            d = $urandom_range(0, 31);
            r = $urandom_range(0, 31);
            run_op(q, d, r, q * d + r, ($urandom_range(0, 3) == 0));
            idle($urandom_range(0, 2));
        end
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rdm.md
# rdm

Sequential shift-and-add reconstruction unit: the inverse of the restoring divider. Given quotient, divisor and remainder, it computes dividendo = quociente × divisor + resto over N+1 clock cycles. It uses the same start/count style as the divider. Its main uses are closed-loop division checking (divider output fed straight back in) and as a general N×N sequential multiplier with addend.

## Interface

Parameters:
- N, default 5: operand width in bits. Must be ≥ 2.

Ports:
- clk  input  1: system clock. Every register updates on its rising edge.
- rst  input  1: reset, asynchronous, active-low. rst = 0 clears all state immediately.
- start  input  1: operation request. Sampled only in IDLE.
- quociente  input  N: multiplier operand.
- divisor  input  N: multiplicand operand.
- resto  input  N: addend. Not range-checked against divisor.
- dividendo  output  2N: result. Holds its value until the next accepted start or reset.
- count  output  $clog2(N+1): iterations remaining.
- busy  output  1: high while an operation is in flight.
- done  output  1: one-cycle pulse when dividendo becomes valid.

## Operation

- Internal registers:
  - A [N:0]: accumulator with carry bit.
  - Q [N-1:0]: multiplier shift register.
  - M [N-1:0]: latched divisor.
  - R [N-1:0]: latched resto.
- The product is P = {A[N-1:0], Q}, 2N bits. dividendo is driven from a dedicated register. It is not driven from P while busy.
- IDLE:
  - busy = 0.
  - On start = 1, load A = 0, Q = quociente, M = divisor, R = resto and count = N, then go to CALC.
  - Operands are captured on the start edge only. Later input changes are ignored.
- CALC, one iteration per edge:
  - If Q[0] = 1, compute A + M into N+1 bits; otherwise use A unchanged.
  - Shift {A, Q} right by one with 0 entering the top bit.
  - Decrement count.
  - When count reaches 0 after this edge, go to SOMA.
- SOMA:
  - Load dividendo = P + zero-extended R, as a 2N-bit add.
  - Set done = 1 and go to IDLE.
- Width rule: the maximum value is (2^N−1)^2 + (2^N−1) = 2^2N − 2^N, which always fits in 2N bits. Overflow cannot occur, so no flag is provided.
- start while busy = 1 is ignored. No queueing.
- divisor = 0: result equals resto.
- quociente = 0: result equals resto.
- resto ≥ divisor: computed arithmetically, with no error indication.
- Reset at any time, including mid-CALC: the state returns to IDLE immediately. The result of the aborted operation is discarded, with no done pulse.

## Timing

- Reset values: dividendo = 0, count = 0, busy = 0, done = 0. State is IDLE and A, Q, M, R = 0.
- Edge 0 is the IDLE edge with start = 1:
  - busy rises after edge 0.
  - count = N after edge 0.
- CALC edges 1..N: count steps N−1 … 0.
- Edge N+1 (SOMA):
  - dividendo becomes valid.
  - done = 1 for exactly one cycle.
  - busy falls.
- Total latency: N+1 cycles from the start edge to valid output (6 cycles for N = 5). Initiation interval is N+2 cycles.
- During the done cycle the state is IDLE, so start may be accepted back-to-back. done then drops on the next edge while busy rises.
- dividendo is unchanged during CALC. It changes only on a SOMA edge or on reset.
- count is 0 in IDLE.

## Test plan

- Q = 2, D = 5, R = 1, start for one cycle:
  - dividendo = 11.
  - done is high exactly 6 edges after the start edge.
  - busy is high during the 6 cycles in between.
- Maximum operands: Q = 31, D = 31, R = 31 gives dividendo = 992. Q = 0, D = 0, R = 0 gives 0. D = 0, Q = 7, R = 3 gives 3.
- Start ignored while busy:
  - Launch Q = 4, D = 3, R = 2.
  - Pulse start again at cycle 3 with other operands, and change the inputs mid-operation.
  - Required: the result is 14 and there is a single done pulse.
- Reset mid-operation: assert rst = 0 at cycle 3 of a run.
  - All outputs go to 0 asynchronously.
  - No done pulse.
  - The next operation, Q = 13 (multiplier) and D = 3 (multiplicand) with addend R = 0, gives 39.
- Back-to-back: issue a second start during the done cycle. Both results are correct, and the done pulses are N+2 cycles apart.
- Exhaustive closed loop, N = 5: for all i in 0..31 and j in 1..31, drive Q = i/j, D = j, R = i%j. Required: dividendo equals i in every case.
